// File: rtl/noc_pkg.sv
`default_nettype none
// ============================================================================
// Module      : noc_pkg
// Description : Shared NoC definitions. Holds the port index map, the flit
//               type codes and the XY routing function.
// Revision    : 1.0 - initial release
// ============================================================================
package noc_pkg;

  // Width of a port index. Five ports fit in three bits.
  localparam int PORT_W = 3;

  localparam logic [PORT_W-1:0] PORT_LOCAL = 3'd0;
  localparam logic [PORT_W-1:0] PORT_NORTH = 3'd1;
  localparam logic [PORT_W-1:0] PORT_EAST  = 3'd2;
  localparam logic [PORT_W-1:0] PORT_SOUTH = 3'd3;
  localparam logic [PORT_W-1:0] PORT_WEST  = 3'd4;

  typedef enum logic [1:0] {
    FLIT_HEADER = 2'd0,
    FLIT_BODY   = 2'd1,
    FLIT_TAIL   = 2'd2
  } flit_type_e;

  // Dimension-ordered routing: resolve X first, then Y. The destination is
  // passed zero-extended so one function serves any address width; the low
  // half of the address is X and the high half is Y.
  function automatic logic [PORT_W-1:0] xy_route(
    input logic [31:0] dest,
    input int unsigned addr_size,
    input logic [31:0] x,
    input logic [31:0] y
  );
    int unsigned half;
    logic [31:0] dx;
    logic [31:0] dy;
    half = addr_size / 2;
    dx   = dest & ((32'd1 << half) - 32'd1);
    dy   = (dest >> half) & ((32'd1 << (addr_size - half)) - 32'd1);
    if (dx > x)      return PORT_EAST;
    else if (dx < x) return PORT_WEST;
    else if (dy > y) return PORT_NORTH;
    else if (dy < y) return PORT_SOUTH;
    else             return PORT_LOCAL;
  endfunction

endpackage
`default_nettype wire

// File: rtl/rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : rr_arbiter
// Description : One output port's owner tracker. It picks a round-robin
//               winner among the candidates while idle, then holds that
//               owner until it releases.
// Revision    : 1.0 - initial release
// ============================================================================
module rr_arbiter #(
  parameter int N     = 5,
  parameter int SEL_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N-1:0]     cand,
  input  logic             rel,
  output logic             busy,
  output logic [SEL_W-1:0] owner
);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_e;

  state_e           r_state;
  logic [SEL_W-1:0] r_ptr;
  logic             w_found;
  logic [SEL_W-1:0] w_win;

  // Pick the first candidate at or after the pointer, wrapping around.
  always_comb begin
    int tmp;
    w_found = 1'b0;
    w_win   = '0;
    for (int k = 0; k < N; k++) begin
      tmp = int'(r_ptr) + k;
      if (tmp >= N) tmp = tmp - N;
      if (!w_found && cand[tmp]) begin
        w_found = 1'b1;
        w_win   = SEL_W'(tmp);
      end
    end
  end

  // Idle/busy lock. The pointer moves only on release, so a packet's win
  // never changes priority until that packet has left.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      busy    <= 1'b0;
      owner   <= '0;
      r_ptr   <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_found) begin
            r_state <= ST_BUSY;
            busy    <= 1'b1;
            owner   <= w_win;
          end
        end
        ST_BUSY: begin
          if (rel) begin
            r_state <= ST_IDLE;
            busy    <= 1'b0;
            owner   <= '0;
            r_ptr   <= (owner == SEL_W'(N - 1)) ? '0 : owner + 1'b1;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: rtl/switch_allocator.sv
`default_nettype none
// ============================================================================
// Module      : switch_allocator
// Description : Router switch allocator. It XY-routes each requesting input,
//               runs one round-robin lock per output and drives the grants
//               and the crossbar select/valid.
// Revision    : 1.0 - initial release
// ============================================================================
module switch_allocator
  import noc_pkg::*;
#(
  parameter int NUM_PORTS    = 5,
  parameter int ADDRESS_SIZE = 4,
  parameter int ROUTER_X     = 0,
  parameter int ROUTER_Y     = 0,
  localparam int SEL_W       = $clog2(NUM_PORTS)
) (
  input  logic                                    clk,
  input  logic                                    rst_n,
  input  logic [NUM_PORTS-1:0]                    req,
  input  logic [NUM_PORTS-1:0][ADDRESS_SIZE-1:0]  dest,
  output logic [NUM_PORTS-1:0]                    grant,
  output logic [NUM_PORTS-1:0]                    out_busy,
  output logic [NUM_PORTS-1:0][SEL_W-1:0]         out_sel
);

  logic [PORT_W-1:0]                 w_route [NUM_PORTS];
  logic [NUM_PORTS-1:0]              w_busy;
  logic [NUM_PORTS-1:0][SEL_W-1:0]   w_owner;

  // Per-input routing. Once an input is granted its candidate bit is masked,
  // so later dest changes cannot move an in-flight packet.
  for (genvar i = 0; i < NUM_PORTS; i++) begin : g_route
    assign w_route[i] = xy_route(32'(dest[i]), ADDRESS_SIZE,
                                 32'(ROUTER_X), 32'(ROUTER_Y));

    // U-turns are legal but unusual; count them when they occur.
    uturn_cov : cover property (@(posedge clk) disable iff (!rst_n)
                                req[i] && (w_route[i] == PORT_W'(i)));
  end

  // One arbiter per output, fed by its column of the candidate matrix.
  for (genvar o = 0; o < NUM_PORTS; o++) begin : g_out
    logic [NUM_PORTS-1:0] w_cand;
    logic                 w_rel;

    // Candidates: requesting, not yet granted, routed to this output.
    always_comb begin
      w_cand = '0;
      for (int i = 0; i < NUM_PORTS; i++) begin
        w_cand[i] = req[i] & ~grant[i] & (w_route[i] == PORT_W'(o));
      end
    end

    assign w_rel = ~req[w_owner[o]];

    rr_arbiter #(
      .N     (NUM_PORTS),
      .SEL_W (SEL_W)
    ) u_arb (
      .clk   (clk),
      .rst_n (rst_n),
      .cand  (w_cand),
      .rel   (w_rel),
      .busy  (w_busy[o]),
      .owner (w_owner[o])
    );
  end

  // Each input owns at most one output, so OR-reducing the owner decode
  // gives its grant.
  always_comb begin
    grant = '0;
    for (int o = 0; o < NUM_PORTS; o++) begin
      if (w_busy[o]) grant[w_owner[o]] = 1'b1;
    end
  end

  assign out_busy = w_busy;
  assign out_sel  = w_owner;

endmodule
`default_nettype wire

// File: tb/tb_switch_allocator.sv
`default_nettype none
// ============================================================================
// Module      : tb_switch_allocator
// Description : Self-checking bench for switch_allocator at router (1,1).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_switch_allocator;
  localparam int NP = 5;
  localparam int AW = 4;
  localparam int RX = 1;
  localparam int RY = 1;
  localparam int SW = 3;

  logic                    clk;
  logic                    rst_n;
  logic [NP-1:0]           req;
  logic [NP-1:0][AW-1:0]   dest;
  logic [NP-1:0]           grant;
  logic [NP-1:0]           out_busy;
  logic [NP-1:0][SW-1:0]   out_sel;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: who owns each output and where its rotation starts.
  int m_busy  [NP];
  int m_owner [NP];
  int m_ptr   [NP];

  switch_allocator #(
    .NUM_PORTS    (NP),
    .ADDRESS_SIZE (AW),
    .ROUTER_X     (RX),
    .ROUTER_Y     (RY)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .req      (req),
    .dest     (dest),
    .grant    (grant),
    .out_busy (out_busy),
    .out_sel  (out_sel)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int ref_route(input logic [AW-1:0] d);
    int dx;
    int dy;
    dx = int'(d) % 4;
    dy = int'(d) / 4;
    if (dx > RX) return 2;
    if (dx < RX) return 4;
    if (dy > RY) return 1;
    if (dy < RY) return 3;
    return 0;
  endfunction

  function automatic logic [NP-1:0] model_grant();
    logic [NP-1:0] g;
    g = '0;
    for (int o = 0; o < NP; o++) if (m_busy[o] != 0) g[m_owner[o]] = 1'b1;
    return g;
  endfunction

  function automatic logic [NP-1:0] model_busy();
    logic [NP-1:0] b;
    for (int o = 0; o < NP; o++) b[o] = (m_busy[o] != 0);
    return b;
  endfunction

  function automatic logic [NP-1:0][SW-1:0] model_sel();
    logic [NP-1:0][SW-1:0] s;
    for (int o = 0; o < NP; o++) s[o] = SW'(m_owner[o]);
    return s;
  endfunction

  task automatic model_reset();
    for (int o = 0; o < NP; o++) begin
      m_busy[o] = 0; m_owner[o] = 0; m_ptr[o] = 0;
    end
  endtask

  // Advance the model by one edge from the inputs currently applied.
  task automatic model_step();
    logic [NP-1:0] g;
    int i;
    g = model_grant();
    for (int o = 0; o < NP; o++) begin
      if (m_busy[o] != 0) begin
        if (!req[m_owner[o]]) begin
          m_ptr[o]   = (m_owner[o] + 1) % NP;
          m_busy[o]  = 0;
          m_owner[o] = 0;
        end
      end else begin
        for (int k = 0; k < NP; k++) begin
          i = (m_ptr[o] + k) % NP;
          if (m_busy[o] == 0 && req[i] && !g[i] && ref_route(dest[i]) == o) begin
            m_busy[o]  = 1;
            m_owner[o] = i;
          end
        end
      end
    end
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    req   = '0;
    dest  = '0;
    model_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    req   = '1;
    dest  = '0;
    #12;
    n_checks++;
    if (grant !== 5'b0) begin n_fail++; $display("FAIL reset_grant: got %b expected %b", grant, 5'b0); end
    n_checks++;
    if (out_busy !== 5'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected %b", out_busy, 5'b0); end
    n_checks++;
    if (out_sel !== 15'b0) begin n_fail++; $display("FAIL reset_sel: got %h expected %h", out_sel, 15'b0); end
    do_reset();
  endtask

  task automatic test_local();
    do_reset();
    req[0]  = 1'b1;
    dest[0] = 4'b0101;
    tick();
    n_checks++;
    if (grant !== 5'b00001) begin n_fail++; $display("FAIL local_grant: got %b expected %b", grant, 5'b00001); end
    n_checks++;
    if (out_busy !== 5'b00001) begin n_fail++; $display("FAIL local_busy: got %b expected %b", out_busy, 5'b00001); end
    n_checks++;
    if (out_sel[0] !== 3'd0) begin n_fail++; $display("FAIL local_sel: got %0d expected 0", out_sel[0]); end
  endtask

  // Contention on EAST, dest change while owning, then release and regrant.
  task automatic test_contention();
    do_reset();
    req[1] = 1'b1; dest[1] = 4'b0111;
    req[3] = 1'b1; dest[3] = 4'b0111;
    tick();
    n_checks++;
    if (grant !== 5'b00010) begin n_fail++; $display("FAIL east_first: got %b expected %b", grant, 5'b00010); end
    dest[1] = 4'b0100;
    tick();
    n_checks++;
    if (out_sel[2] !== 3'd1 || out_busy[4] !== 1'b0) begin
      n_fail++; $display("FAIL dest_latched: got sel %0d west_busy %b expected sel 1 west_busy 0", out_sel[2], out_busy[4]);
    end
    req[1] = 1'b0;
    tick();
    n_checks++;
    if (grant !== 5'b00000 || out_busy[2] !== 1'b0) begin
      n_fail++; $display("FAIL east_release: got grant %b busy %b expected grant 00000 busy 0", grant, out_busy[2]);
    end
    tick();
    n_checks++;
    if (grant !== 5'b01000 || out_sel[2] !== 3'd3) begin
      n_fail++; $display("FAIL east_regrant: got grant %b sel %0d expected grant 01000 sel 3", grant, out_sel[2]);
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    req[1] = 1'b1; dest[1] = 4'b0111;
    req[3] = 1'b1; dest[3] = 4'b0111;
    tick();
    #2;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (grant !== 5'b0 || out_busy !== 5'b0 || out_sel !== 15'b0) begin
      n_fail++; $display("FAIL async_reset: got grant %b busy %b sel %h expected all zero", grant, out_busy, out_sel);
    end
    do_reset();
  endtask

  task automatic test_rr_rotation();
    int order[$];
    int cnt[NP];
    int exp_order[4];
    logic [NP-1:0] prev;
    int i;
    exp_order = '{0, 2, 4, 0};
    do_reset();
    for (int k = 0; k < NP; k++) cnt[k] = 0;
    dest[0] = 4'b0100; dest[2] = 4'b0100; dest[4] = 4'b0100;
    req = 5'b10101;
    prev = '0;
    for (int c = 0; c < 60 && order.size() < 4; c++) begin
      @(posedge clk);
      #1;
      for (int k = 0; k < 3; k++) begin
        i = 2 * k;
        if (grant[i] && !prev[i]) order.push_back(i);
      end
      prev = grant;
      for (int k = 0; k < 3; k++) begin
        i = 2 * k;
        if (grant[i]) begin
          cnt[i]++;
          if (cnt[i] == 3) req[i] = 1'b0;
        end else begin
          cnt[i] = 0;
          req[i] = 1'b1;
        end
      end
    end
    n_checks++;
    if (order.size() < 4) begin
      n_fail++; $display("FAIL rr_timeout: got %0d grants expected 4", order.size());
    end else begin
      for (int k = 0; k < 4; k++) begin
        n_checks++;
        if (order[k] != exp_order[k]) begin
          n_fail++; $display("FAIL rr_order[%0d]: got %0d expected %0d", k, order[k], exp_order[k]);
        end
      end
    end
  endtask

  task automatic test_parallel();
    do_reset();
    req[0] = 1'b1; dest[0] = 4'b1001;
    req[2] = 1'b1; dest[2] = 4'b0001;
    tick();
    n_checks++;
    if (grant !== 5'b00101 || out_busy !== 5'b01010) begin
      n_fail++; $display("FAIL parallel_grant: got grant %b busy %b expected grant 00101 busy 01010", grant, out_busy);
    end
    n_checks++;
    if (out_sel[1] !== 3'd0 || out_sel[3] !== 3'd2) begin
      n_fail++; $display("FAIL parallel_sel: got north %0d south %0d expected north 0 south 2", out_sel[1], out_sel[3]);
    end
  endtask

  task automatic test_random();
    logic [NP-1:0] g;
    do_reset();
    for (int c = 0; c < 400; c++) begin
      tick();
      n_checks++;
      if (grant !== model_grant()) begin
        n_fail++; $display("FAIL rand_grant cycle %0d: got %b expected %b", c, grant, model_grant());
      end
      n_checks++;
      if (out_busy !== model_busy()) begin
        n_fail++; $display("FAIL rand_busy cycle %0d: got %b expected %b", c, out_busy, model_busy());
      end
      n_checks++;
      if (out_sel !== model_sel()) begin
        n_fail++; $display("FAIL rand_sel cycle %0d: got %h expected %h", c, out_sel, model_sel());
      end
      g = model_grant();
      for (int i = 0; i < NP; i++) begin
        if (!req[i]) begin
          if ($urandom_range(2) == 0) begin
            req[i]  = 1'b1;
            dest[i] = 4'($urandom);
          end
        end else if (g[i]) begin
          if ($urandom_range(3) == 0) req[i] = 1'b0;
          else if ($urandom_range(7) == 0) dest[i] = 4'($urandom);
        end else if ($urandom_range(15) == 0) begin
          req[i] = 1'b0;
        end
      end
    end
  endtask

  initial begin
    rst_n = 1'b0;
    req   = '0;
    dest  = '0;
    model_reset();
    test_reset();
    test_local();
    test_contention();
    test_async_reset();
    test_rr_rotation();
    test_parallel();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
